matrix_keypad_scanner: RTL and testbench
========================================

MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, number of row inputs (2..8).
REQ-002 The block SHALL have parameter COLS, default 4, number of column drives (2..8).
REQ-003 The block SHALL have parameter DWELL, default 4, cycles each column is driven during a scan (>=2).
REQ-004 The block SHALL have parameter DEBOUNCE, default 16, consecutive stable cycles required for press and for release (>=1).
REQ-005 The block SHALL derive local constant CODE_W = clog2(ROWS*COLS), minimum 1.
REQ-006 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 The block SHALL have port row, input, ROWS, active-high row sense, already synchronised externally.
REQ-009 The block SHALL have port col, output, COLS, active-high column drive.
REQ-010 The block SHALL have port code, output, CODE_W, key index = row_index*COLS + col_index.
REQ-011 The block SHALL have port reg_load, output, 1, one-cycle pulse marking code valid.
REQ-012 The block SHALL have port key_held, output, 1, high from the reg_load cycle until release completes.
REQ-013 The block SHALL have port multi_key, output, 1, one-cycle pulse flagging a rejected multi-row press.

Function
REQ-014 The block SHALL implement states IDLE, SCAN, DEBOUNCE, LOAD, HOLD; all outputs registered.
REQ-015 In IDLE, col SHALL be all ones; any row bit high SHALL move to SCAN with column index 0 and dwell counter 0.
REQ-016 In SCAN, col SHALL be one-hot at the current column index, held for exactly DWELL cycles.
REQ-017 In SCAN, row SHALL be sampled on the last dwell cycle only; nonzero -> latch column index and row vector, go to DEBOUNCE.
REQ-018 In SCAN, a zero sample SHALL advance the column; a zero sample on column COLS-1 SHALL return to IDLE (no wrap).
REQ-019 In DEBOUNCE, col SHALL stay on the latched column; row equal to the latched vector increments the counter; any mismatch SHALL return to IDLE with no output.
REQ-020 When DEBOUNCE stable cycles are reached with a one-hot latched row, the block SHALL go to LOAD.
REQ-021 When the latched row has more than one bit set at debounce completion, the block SHALL pulse multi_key for one cycle, leave code unchanged, and go to HOLD.
REQ-022 LOAD SHALL last one cycle: code updated, reg_load=1, key_held=1 in that same cycle, then go to HOLD.
REQ-023 In HOLD, col SHALL be all ones; after DEBOUNCE consecutive cycles with row all zero, key_held SHALL clear and state SHALL return to IDLE.
REQ-024 In HOLD, any nonzero row SHALL restart the release counter; no new press SHALL be reported until IDLE is re-entered.
REQ-025 Press-to-reg_load latency SHALL be (col_index+1)*DWELL + DEBOUNCE + 1 cycles from row rising in IDLE, for a clean press.
REQ-026 code SHALL hold its last value between loads; reg_load and multi_key SHALL never be high in the same cycle.
REQ-027 Counters SHALL be sized clog2(max(DWELL,DEBOUNCE)+1) bits and SHALL saturate, never wrap.
REQ-028 Unused state encodings SHALL return to IDLE on the next clock.

Reset
REQ-029 While reset is high at a rising edge, the block SHALL enter IDLE with col all ones, code=0, reg_load=0, key_held=0, multi_key=0, and all counters 0.
REQ-030 Reset asserted mid-SCAN, mid-DEBOUNCE or mid-HOLD SHALL discard the pending key without any pulse; reset SHALL override all other events in the same cycle.

Structure
REQ-031 State encodings SHALL live in shared package keypad_pkg, together with a clog2 helper function.
REQ-032 The priority and one-hot check on the latched row SHALL be a sub-module, row_encoder (ROWS in; index and onehot flag out).

Verification
REQ-033 Defaults, key row1/col2 held 40 cycles -> single reg_load at cycle 3*4+16+1=29, code=6, key_held high until 16 cycles after release.
REQ-034 Bounce: row1/col0 toggles on 5-cycle periods for 30 cycles, then stable -> exactly one reg_load, code=4, no pulse during bouncing.
REQ-035 Two keys row0 and row3 on col1 simultaneously -> multi_key one pulse, no reg_load, code retains previous value.
REQ-036 Reset asserted during DEBOUNCE of key row3/col3 -> outputs at reset values next cycle, no reg_load; a re-press then yields code=15.
REQ-037 ROWS=2, COLS=8, DWELL=2, DEBOUNCE=3: key row1/col7 -> code=15, CODE_W=4, reg_load at cycle 8*2+3+1=20.
REQ-038 Key released and re-pressed within 10 cycles (<DEBOUNCE) in HOLD -> no second reg_load until 16 clean zero cycles pass.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM encoding and width helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_LOAD     = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    // Ceiling log2, never below 1 so a one-value field still gets a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/row_encoder.sv
// row_encoder: lowest-set-bit index and one-hot flag of a row vector
//   row    - row vector to encode
//   index  - index of the lowest set bit (0 when row is zero)
//   onehot - exactly one bit of row is set
module row_encoder import keypad_pkg::*; #(
    parameter  int ROWS  = 4,
    localparam int IDX_W = clog2(ROWS)
) (
    input  logic [ROWS-1:0]  row,
    output logic [IDX_W-1:0] index,
    output logic             onehot
);

    // Walking downward leaves the lowest set bit as the winner.
    always_comb begin
        index = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (row[i]) index = IDX_W'(i);
    end

    assign onehot = (row != '0) && ((row & (row - ROWS'(1))) == '0);

endmodule

// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner: column-scanning, debounced matrix keypad decoder
//   clock     - rising-edge clock
//   reset     - synchronous active-high reset
//   row       - active-high row sense (already synchronised)
//   col       - active-high column drive
//   code      - key index row*COLS+col, held between loads
//   reg_load  - one-cycle pulse when code is updated
//   key_held  - high from the reg_load cycle until release is debounced
//   multi_key - one-cycle pulse for a rejected multi-row press
module matrix_keypad_scanner import keypad_pkg::*; #(
    parameter  int ROWS     = 4,
    parameter  int COLS     = 4,
    parameter  int DWELL    = 4,
    parameter  int DEBOUNCE = 16,
    localparam int CODE_W   = clog2(ROWS * COLS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] code,
    output logic              reg_load,
    output logic              key_held,
    output logic              multi_key
);

    localparam int CNT_W = clog2(max2(DWELL, DEBOUNCE) + 1);
    localparam int COL_W = clog2(COLS);
    localparam int ROW_W = clog2(ROWS);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

    state_t            state, state_d;
    logic [COL_W-1:0]  col_idx, col_idx_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
    logic [ROWS-1:0]   latched, latched_d;
    logic [COLS-1:0]   col_d;
    logic [CODE_W-1:0] code_d;
    logic              reg_load_d, key_held_d, multi_key_d;
    logic [ROW_W-1:0]  row_idx;
    logic              row_onehot;

    row_encoder #(.ROWS(ROWS)) u_row_encoder (
        .row    (latched),
        .index  (row_idx),
        .onehot (row_onehot)
    );

    // One counter serves dwell, press debounce and release debounce.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_d     = state;
        col_idx_d   = col_idx;
        cnt_d       = cnt;
        latched_d   = latched;
        code_d      = code;
        reg_load_d  = 1'b0;
        multi_key_d = 1'b0;
        key_held_d  = key_held;
        case (state)
            ST_IDLE:
                if (row != '0) begin
                    state_d   = ST_SCAN;
                    col_idx_d = '0;
                    cnt_d     = '0;
                end
            ST_SCAN:
                if (cnt != DWELL_LAST) begin
                    cnt_d = cnt_inc;
                end else if (row != '0) begin
                    state_d   = ST_DEBOUNCE;
                    latched_d = row;
                    cnt_d     = '0;
                end else if (col_idx == COL_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    col_idx_d = col_idx + COL_W'(1);
                    cnt_d     = '0;
                end
            ST_DEBOUNCE:
                if (row != latched) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt != DEB_LAST) begin
                    cnt_d = cnt_inc;
                end else if (row_onehot) begin
                    state_d    = ST_LOAD;
                    cnt_d      = '0;
                    code_d     = CODE_W'(int'(row_idx) * COLS + int'(col_idx));
                    reg_load_d = 1'b1;
                    key_held_d = 1'b1;
                end else begin
                    // Ambiguous press: flag it and wait for full release.
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    multi_key_d = 1'b1;
                end
            ST_LOAD: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD:
                if (row != '0) begin
                    cnt_d = '0;
                end else if (cnt != DEB_LAST) begin
                    cnt_d = cnt_inc;
                end else begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                key_held_d = 1'b0;
            end
        endcase
        // Drive one column while scanning or debouncing, all columns otherwise.
        col_d = (state_d == ST_SCAN || state_d == ST_DEBOUNCE) ? (COLS'(1) << col_idx_d) : '1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            col_idx   <= '0;
            cnt       <= '0;
            latched   <= '0;
            col       <= '1;
            code      <= '0;
            reg_load  <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= state_d;
            col_idx   <= col_idx_d;
            cnt       <= cnt_d;
            latched   <= latched_d;
            col       <= col_d;
            code      <= code_d;
            reg_load  <= reg_load_d;
            key_held  <= key_held_d;
            multi_key <= multi_key_d;
        end
    end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// tb_matrix_keypad_scanner: scoreboard bench for the keypad scanner
module tb_matrix_keypad_scanner;

    typedef struct {
        bit multi;
        int code;
        int cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Default instance: 4x4, DWELL 4, DEBOUNCE 16
    logic [15:0] keys = '0;
    logic [3:0]  row, col, code;
    logic        reg_load, key_held, multi_key;

    // Small instance: 2x8, DWELL 2, DEBOUNCE 3
    logic [15:0] keys2 = '0;
    logic [1:0]  row2;
    logic [7:0]  col2;
    logic [3:0]  code2;
    logic        reg_load2, key_held2, multi_key2;

    matrix_keypad_scanner dut (
        .clock(clock), .reset(reset), .row(row), .col(col), .code(code),
        .reg_load(reg_load), .key_held(key_held), .multi_key(multi_key)
    );

    matrix_keypad_scanner #(.ROWS(2), .COLS(8), .DWELL(2), .DEBOUNCE(3)) dut2 (
        .clock(clock), .reset(reset), .row(row2), .col(col2), .code(code2),
        .reg_load(reg_load2), .key_held(key_held2), .multi_key(multi_key2)
    );

    // Keypad model: a pressed key connects its column drive to its row.
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) row[r] = |(keys[r*4 +: 4] & col);
    end

    always_comb begin
        row2 = '0;
        for (int r = 0; r < 2; r++) row2[r] = |(keys2[r*8 +: 8] & col2);
    end

    exp_t q0[$];
    exp_t q1[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push0(input bit m, input int c, input int t);
        exp_t e;
        e.multi = m;
        e.code  = c;
        e.cyc   = t;
        q0.push_back(e);
    endtask

    task automatic push1(input bit m, input int c, input int t);
        exp_t e;
        e.multi = m;
        e.code  = c;
        e.cyc   = t;
        q1.push_back(e);
    endtask

    // Monitors: every pulse must match the next expected event exactly.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (reg_load || multi_key)) begin
            check("exclusive0", reg_load & multi_key, 0);
            check("pending0", q0.size() > 0, 1);
            if (reg_load) check("held_on_load0", key_held, 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("kind0", multi_key, e.multi);
                check("code0", code, e.code);
                check("latency0", cyc, e.cyc);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && (reg_load2 || multi_key2)) begin
            check("exclusive1", reg_load2 & multi_key2, 0);
            check("pending1", q1.size() > 0, 1);
            if (reg_load2) check("held_on_load1", key_held2, 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("kind1", multi_key2, e.multi);
                check("code1", code2, e.code);
                check("latency1", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;
        int rel;
        reset = 1'b1;
        tick(3);
        @(negedge clock);
        check("rst_col", col, 4'hF);
        check("rst_code", code, 0);
        check("rst_load", reg_load, 0);
        check("rst_held", key_held, 0);
        check("rst_multi", multi_key, 0);
        check("rst_col2", col2, 8'hFF);
        check("rst_code2", code2, 0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // row1/col2 held 40 cycles: load at +29, code 6, released debounced 16 later
        t0 = cyc;
        keys = 16'h0040;
        push0(1'b0, 6, t0 + 29);
        tick_to(t0 + 40);
        keys = '0;
        tick_to(t0 + 55);
        @(negedge clock);
        check("held_release_15", key_held, 1);
        tick(1);
        @(negedge clock);
        check("held_release_16", key_held, 0);
        check("drained_basic", q0.size(), 0);
        tick(5);

        // row1/col0 bouncing on 5-cycle halves for 30 cycles; each bounce
        // window ends in IDLE, so the stable press from t0+30 loads at +21.
        t0 = cyc;
        push0(1'b0, 4, t0 + 30 + 21);
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0010 : 16'h0000;
            tick(5);
        end
        keys = 16'h0010;
        tick(40);
        keys = '0;
        tick(20);
        check("bounce_released", key_held, 0);
        check("drained_bounce", q0.size(), 0);

        // row0 and row3 on col1: multi pulse at 2*4+16+1, code stays 4
        t0 = cyc;
        keys = 16'h2002;
        push0(1'b1, 4, t0 + 25);
        tick_to(t0 + 26);
        @(negedge clock);
        check("multi_no_held", key_held, 0);
        check("multi_code_kept", code, 4);
        tick(20);
        keys = '0;
        tick(20);
        check("drained_multi", q0.size(), 0);

        // row3/col3 interrupted by reset mid-debounce
        t0 = cyc;
        keys = 16'h8000;
        tick_to(t0 + 24);
        @(negedge clock);
        check("debounce_col3", col, 4'b1000);
        reset = 1'b1;
        tick(1);
        @(negedge clock);
        check("midrst_col", col, 4'hF);
        check("midrst_code", code, 0);
        check("midrst_load", reg_load, 0);
        check("midrst_held", key_held, 0);
        check("midrst_multi", multi_key, 0);
        tick(1);
        reset = 1'b0;
        keys = '0;
        tick(20);

        // Re-press row3/col3: code 15 at 4*4+16+1, then a short release
        // and re-press inside HOLD must not clear key_held early.
        t1 = cyc;
        keys = 16'h8000;
        push0(1'b0, 15, t1 + 33);
        tick_to(t1 + 40);
        keys = '0;
        tick_to(t1 + 46);
        keys = 16'h8000;
        tick_to(t1 + 50);
        @(negedge clock);
        check("hold_repress_held", key_held, 1);
        tick_to(t1 + 54);
        keys = '0;
        rel = cyc;
        tick_to(rel + 15);
        @(negedge clock);
        check("hold_restart_15", key_held, 1);
        tick(1);
        @(negedge clock);
        check("hold_restart_16", key_held, 0);
        check("drained_reset", q0.size(), 0);
        tick(5);

        // Fresh press after IDLE: row2/col1 -> code 9 at 2*4+16+1
        t0 = cyc;
        keys = 16'h0200;
        push0(1'b0, 9, t0 + 25);
        tick(30);
        keys = '0;
        tick(20);

        // Small instance: row1/col7 -> code 15 at 8*2+3+1
        t0 = cyc;
        keys2 = 16'h8000;
        push1(1'b0, 15, t0 + 20);
        tick(25);
        keys2 = '0;
        tick(6);
        @(negedge clock);
        check("small_released", key_held2, 0);
        tick(4);

        check("drained_q0", q0.size(), 0);
        check("drained_q1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
